// File: rtl/cam_cmd_sequencer.sv
// cam_cmd_sequencer: command front-end for a 32-entry CAM.
// Buffers write/search commands in a FIFO and issues each one to the CAM as a
// single-cycle strobe. For a search it waits CAM_LATENCY cycles, captures the
// match address/flag and returns them over a valid/ready result handshake.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   cmd_valid/cmd_ready           command handshake (cmd_ready = FIFO not full)
//   cmd_write, cmd_addr, cmd_data command payload (write=1, search=0)
//   cam_write, cam_search         single-cycle strobes to the CAM
//   cam_addr, cam_data            address / data-or-key to the CAM (held)
//   cam_match_addr, cam_found     CAM search result inputs
//   res_valid/res_ready           result handshake
//   res_addr, res_found           captured search result
//   stat_writes, stat_searches,
//   stat_hits                     saturating counters, only when the macro
//                                 CAM_SEQ_STATS_EN is defined
module cam_cmd_sequencer #(
    parameter int unsigned ADDR_W      = 5,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned CAM_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              cam_write,
    output logic              cam_search,
    output logic [ADDR_W-1:0] cam_addr,
    output logic [DATA_W-1:0] cam_data,
    input  logic [ADDR_W-1:0] cam_match_addr,
    input  logic              cam_found,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ADDR_W-1:0] res_addr,
    output logic              res_found
`ifdef CAM_SEQ_STATS_EN
    ,
    output logic [7:0]        stat_writes,
    output logic [7:0]        stat_searches,
    output logic [7:0]        stat_hits
`endif
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(CAM_LATENCY + 1);

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Command FIFO storage and pointers (extra MSB separates full from empty)
    cmd_t             fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic [PTR_W:0]   wr_ptr_next;
    logic [PTR_W:0]   rd_ptr_next;
    logic             push;
    logic             pop;
    logic             empty;
    logic             full_next;
    cmd_t             head;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic              capture;

    logic              cmd_ready_next;
    logic              cam_write_next;
    logic              cam_search_next;
    logic [ADDR_W-1:0] cam_addr_next;
    logic [DATA_W-1:0] cam_data_next;
    logic              res_valid_next;
    logic [ADDR_W-1:0] res_addr_next;
    logic              res_found_next;

    assign push  = cmd_valid & cmd_ready;
    assign empty = (wr_ptr == rd_ptr);
    assign head  = fifo_mem[rd_ptr[PTR_W-1:0]];

    // FIFO payload write; storage needs no reset since pointers gate it
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr[PTR_W-1:0]] <= cmd_t'{write: cmd_write, addr: cmd_addr, data: cmd_data};
        end
    end

    // Next-state, strobe, result and pointer logic
    always_comb begin
        state_next      = state;
        cnt_next        = cnt;
        pop             = 1'b0;
        capture         = 1'b0;
        cam_write_next  = 1'b0;
        cam_search_next = 1'b0;
        cam_addr_next   = cam_addr;
        cam_data_next   = cam_data;
        res_valid_next  = 1'b0;
        res_addr_next   = res_addr;
        res_found_next  = res_found;

        case (state)
            IDLE: begin
                if (!empty) begin
                    pop             = 1'b1;
                    cam_write_next  = head.write;
                    cam_search_next = ~head.write;
                    cam_addr_next   = head.write ? head.addr : '0;
                    cam_data_next   = head.data;
                    state_next      = ISSUE;
                end
            end
            ISSUE: begin
                // The registered strobe tells us which command is in flight
                if (cam_search) begin
                    cnt_next   = CNT_W'(CAM_LATENCY);
                    state_next = WAIT;
                end else begin
                    state_next = IDLE;
                end
            end
            WAIT: begin
                cnt_next = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    capture    = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                // res_valid rises one cycle after entering RESP
                if (res_valid && res_ready) begin
                    state_next = IDLE;
                end else begin
                    res_valid_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        if (capture) begin
            res_addr_next  = cam_match_addr;
            res_found_next = cam_found;
        end

        wr_ptr_next    = wr_ptr + (PTR_W + 1)'(push);
        rd_ptr_next    = rd_ptr + (PTR_W + 1)'(pop);
        full_next      = (wr_ptr_next[PTR_W] != rd_ptr_next[PTR_W]) &&
                         (wr_ptr_next[PTR_W-1:0] == rd_ptr_next[PTR_W-1:0]);
        cmd_ready_next = ~full_next;
    end

    // State, pointer and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            cmd_ready  <= 1'b1;
            cam_write  <= 1'b0;
            cam_search <= 1'b0;
            cam_addr   <= '0;
            cam_data   <= '0;
            res_valid  <= 1'b0;
            res_addr   <= '0;
            res_found  <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            wr_ptr     <= wr_ptr_next;
            rd_ptr     <= rd_ptr_next;
            cmd_ready  <= cmd_ready_next;
            cam_write  <= cam_write_next;
            cam_search <= cam_search_next;
            cam_addr   <= cam_addr_next;
            cam_data   <= cam_data_next;
            res_valid  <= res_valid_next;
            res_addr   <= res_addr_next;
            res_found  <= res_found_next;
        end
    end

`ifdef CAM_SEQ_STATS_EN
    // Saturating activity counters
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_writes   <= '0;
            stat_searches <= '0;
            stat_hits     <= '0;
        end else begin
            if (cam_write_next && (stat_writes != 8'hFF)) begin
                stat_writes <= stat_writes + 8'd1;
            end
            if (cam_search_next && (stat_searches != 8'hFF)) begin
                stat_searches <= stat_searches + 8'd1;
            end
            if (capture && cam_found && (stat_hits != 8'hFF)) begin
                stat_hits <= stat_hits + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cam_cmd_sequencer.sv
// Testbench for cam_cmd_sequencer: directed steps plus a randomized phase,
// checked against a transaction-level model (command queue, CAM contents,
// result timing) kept in the bench.
module tb_cam_cmd_sequencer;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
    localparam int LAT    = 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_data;
    logic              cam_write;
    logic              cam_search;
    logic [ADDR_W-1:0] cam_addr;
    logic [DATA_W-1:0] cam_data;
    logic [ADDR_W-1:0] cam_match_addr;
    logic              cam_found;
    logic              res_valid;
    logic              res_ready;
    logic [ADDR_W-1:0] res_addr;
    logic              res_found;
`ifdef CAM_SEQ_STATS_EN
    logic [7:0]        stat_writes;
    logic [7:0]        stat_searches;
    logic [7:0]        stat_hits;
`endif

    cam_cmd_sequencer #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH), .CAM_LATENCY(LAT)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .cam_write(cam_write), .cam_search(cam_search),
        .cam_addr(cam_addr), .cam_data(cam_data),
        .cam_match_addr(cam_match_addr), .cam_found(cam_found),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_addr(res_addr), .res_found(res_found)
`ifdef CAM_SEQ_STATS_EN
        , .stat_writes(stat_writes), .stat_searches(stat_searches), .stat_hits(stat_hits)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { bit wr; int addr; int data; } cmd_m_t;

    cmd_m_t q[$];
    int     mem_val [32];
    bit     mem_ok  [32];
    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    int     n_push, n_pop;
    bit     outstanding;
    int     strobe_cyc, last_strobe_cyc;
    int     exp_raddr;
    bit     exp_rfound;
    int     cd;
    int     n_w, n_s, n_h;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Per-cycle model update and output checks, run at the falling edge
    task automatic monitor();
        cmd_m_t c;
        // CAM model: correct result only in the cycle just before it must be sampled
        if (cd > 0) cd--;
        if (cd == 0) begin
            cam_match_addr = ADDR_W'(exp_raddr);
            cam_found      = exp_rfound;
            cd             = -1;
        end else begin
            cam_match_addr = ADDR_W'($urandom_range(0, 31));
            cam_found      = 1'($urandom_range(0, 1));
        end

        chk("dual_strobe", 32'(cam_write & cam_search), 0);
        if (cam_write || cam_search) begin
            chk("issue_while_busy", 32'(outstanding), 0);
            chk("strobe_spacing", 32'((cyc - last_strobe_cyc) >= 2), 1);
            last_strobe_cyc = cyc;
            chk("strobe_has_cmd", 32'(q.size() > 0), 1);
            if (q.size() > 0) begin
                c = q.pop_front();
                n_pop++;
                chk("strobe_kind", 32'(cam_write), 32'(c.wr));
                chk("cam_addr", 32'(cam_addr), c.wr ? c.addr : 0);
                chk("cam_data", 32'(cam_data), c.data);
                if (c.wr) begin
                    mem_val[c.addr] = c.data;
                    mem_ok[c.addr]  = 1'b1;
                    n_w++;
                end else begin
                    exp_rfound = 1'b0;
                    exp_raddr  = 0;
                    for (int i = 31; i >= 0; i--) begin
                        if (mem_ok[i] && mem_val[i] == c.data) begin
                            exp_rfound = 1'b1;
                            exp_raddr  = i;
                        end
                    end
                    outstanding = 1'b1;
                    strobe_cyc  = cyc;
                    cd          = LAT;
                    n_s++;
                    if (exp_rfound) n_h++;
                end
            end
        end
        chk("cmd_ready", 32'(cmd_ready), 32'((n_push - n_pop) < DEPTH));
        chk("res_valid", 32'(res_valid), 32'(outstanding && ((cyc - strobe_cyc) >= LAT + 2)));
    endtask

    // Advance one clock; handshakes are taken from the values present before the edge
    task automatic tick();
        if (cmd_valid && cmd_ready) begin
            q.push_back('{wr: cmd_write, addr: int'(cmd_addr), data: int'(cmd_data)});
            n_push++;
        end
        if (res_valid && res_ready) begin
            chk("res_addr", 32'(res_addr), exp_raddr);
            chk("res_found", 32'(res_found), 32'(exp_rfound));
            outstanding = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        monitor();
    endtask

    task automatic do_reset(int n);
        rst       = 1'b1;
        cmd_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            chk("rst_res_valid", 32'(res_valid), 0);
            chk("rst_cmd_ready", 32'(cmd_ready), 1);
            chk("rst_strobes", 32'({cam_write, cam_search}), 0);
        end
        rst = 1'b0;
        q.delete();
        n_push = 0; n_pop = 0; outstanding = 1'b0; cd = -1;
        last_strobe_cyc = cyc - 10; strobe_cyc = 0;
        n_w = 0; n_s = 0; n_h = 0;
    endtask

    task automatic push_cmd(bit w, int a, int d);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = ADDR_W'(a);
        cmd_data  = DATA_W'(d);
        for (int i = 0; i < 50 && !cmd_ready; i++) tick();
        chk("push_wait", 32'(cmd_ready), 1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        for (int i = 0; i < 2000 && (q.size() > 0 || outstanding); i++) tick();
        chk("drain_done", 32'(q.size() == 0 && !outstanding), 1);
    endtask

    initial begin
        int wq[$];
        bit seen;

        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_data = '0;
        res_ready = 1'b1; cam_match_addr = '0; cam_found = 1'b0;
        for (int i = 0; i < 32; i++) begin mem_ok[i] = 1'b0; mem_val[i] = 0; end
        exp_raddr = 0; exp_rfound = 1'b0;

        // Reset values
        do_reset(2);
        chk("rst_cam_addr", 32'(cam_addr), 0);
        chk("rst_cam_data", 32'(cam_data), 0);
        chk("rst_res_addr", 32'(res_addr), 0);
        chk("rst_res_found", 32'(res_found), 0);

        // Single write: strobe one cycle after acceptance, exactly one cycle wide
        push_cmd(1'b1, 5, 8'hA3);
        chk("wr_not_yet", 32'(cam_write), 0);
        tick();
        chk("wr_strobe", 32'(cam_write), 1);
        chk("wr_addr", 32'(cam_addr), 5);
        chk("wr_data", 32'(cam_data), 32'h A3);
        tick();
        chk("wr_strobe_off", 32'(cam_write), 0);
        tick();

        // Search hit: res_valid three cycles after the strobe cycle
        push_cmd(1'b0, 7, 8'hA3);
        tick();
        chk("srch_strobe", 32'(cam_search), 1);
        chk("srch_addr0", 32'(cam_addr), 0);
        tick();
        chk("srch_rv_s1", 32'(res_valid), 0);
        tick();
        chk("srch_rv_s2", 32'(res_valid), 0);
        tick();
        chk("srch_rv_s3", 32'(res_valid), 1);
        chk("srch_hit_addr", 32'(res_addr), 5);
        chk("srch_hit_found", 32'(res_found), 1);
        tick();
        chk("srch_rv_done", 32'(res_valid), 0);

        // Backpressure: result held, FIFO fills with writes
        res_ready = 1'b0;
        push_cmd(1'b0, 0, 8'h3C);
        for (int k = 0; k < 4; k++) push_cmd(1'b1, 10 + k, 8'h40 + k);
        chk("bp_full", 32'(cmd_ready), 0);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 5'd20; cmd_data = 8'hEE;
        repeat (3) tick();
        cmd_valid = 1'b0;
        repeat (3) tick();
        chk("bp_rv_held", 32'(res_valid), 1);
        res_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (cam_write) wq.push_back(cyc);
        end
        chk("bp_write_count", 32'(wq.size()), 4);
        for (int k = 1; k < wq.size(); k++) chk("bp_cadence", 32'(wq[k] - wq[k-1]), 2);

        // Search miss followed by a write that must wait for the result handshake
        res_ready = 1'b0;
        push_cmd(1'b0, 0, 8'h11);
        push_cmd(1'b1, 31, 8'h11);
        repeat (6) tick();
        chk("miss_rv", 32'(res_valid), 1);
        chk("miss_found", 32'(res_found), 0);
        res_ready = 1'b1;
        tick();
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            if (cam_write) begin
                seen = 1'b1;
                chk("miss_wr_addr", 32'(cam_addr), 31);
            end
        end
        chk("miss_wr_seen", 32'(seen), 1);
        tick();

        // Reset in the middle of a search with commands still queued
        push_cmd(1'b0, 0, 8'hA3);
        push_cmd(1'b1, 1, 8'h21);
        push_cmd(1'b1, 2, 8'h22);
        do_reset(2);
        repeat (8) tick();
        chk("post_rst_rv", 32'(res_valid), 0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            cmd_valid = ($urandom_range(0, 99) < 40);
            cmd_write = 1'($urandom_range(0, 1));
            cmd_addr  = ADDR_W'($urandom_range(0, 7));
            cmd_data  = DATA_W'($urandom_range(0, 7) * 16 + 1);
            res_ready = ($urandom_range(0, 99) < 60);
            tick();
        end
        drain();

`ifdef CAM_SEQ_STATS_EN
        // Statistics counters and saturation
        do_reset(1);
        push_cmd(1'b1, 3, 8'h77);
        push_cmd(1'b1, 4, 8'h78);
        push_cmd(1'b1, 6, 8'h79);
        push_cmd(1'b0, 0, 8'h78);
        push_cmd(1'b0, 0, 8'h55);
        drain();
        chk("stat_writes", 32'(stat_writes), 3);
        chk("stat_searches", 32'(stat_searches), 2);
        chk("stat_hits", 32'(stat_hits), 32'(n_h));
        chk("stat_hits_one", 32'(stat_hits), 1);
        for (int k = 0; k < 300; k++) push_cmd(1'b1, k % 32, k % 256);
        drain();
        chk("stat_writes_sat", 32'(stat_writes), 255);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cam_cmd_sequencer.md
# cam_cmd_sequencer

Command front-end placed directly upstream of the 32-entry, 8-bit CAM in the top-level mux/demux wrapper. It accepts write and search commands over a valid/ready handshake and buffers them in a small FIFO. It issues each command to the CAM as a single-cycle strobe. For searches it waits a fixed latency, captures the CAM's match address and found flag, and returns them on a second valid/ready handshake.

## Interface
Parameters:
- `ADDR_W`, 5, CAM address width.
- `DATA_W`, 8, CAM data/key width.
- `FIFO_DEPTH`, 4, command FIFO entries; must be a power of two, ≥2.
- `CAM_LATENCY`, 1, cycles from issue strobe to valid CAM result; must be ≥1.

Ports:
- `clk` in 1: single clock; everything is rising-edge.
- `rst` in 1: reset, synchronous and active-high.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: FIFO can accept a command.
- `cmd_write` in 1: 1 = write `cmd_data` at `cmd_addr`; 0 = search for `cmd_data`.
- `cmd_addr` in ADDR_W: write address; ignored for searches.
- `cmd_data` in DATA_W: write data or search key.
- `cam_write` out 1: write strobe to the CAM.
- `cam_search` out 1: search strobe to the CAM.
- `cam_addr` out ADDR_W: address to the CAM.
- `cam_data` out DATA_W: data or key to the CAM.
- `cam_match_addr` in ADDR_W: match address from the CAM.
- `cam_found` in 1: match flag from the CAM.
- `res_valid` out 1: search result available.
- `res_ready` in 1: consumer accepts the result.
- `res_addr` out ADDR_W: captured match address.
- `res_found` out 1: captured match flag.

## Operation
- **Reset values:** all outputs are 0 except `cmd_ready`, which is 1. The FIFO is empty and the FSM is in IDLE.
- **FIFO and handshake:** a push happens on `cmd_valid & cmd_ready`. `cmd_ready = !full`, registered from occupancy. There is no bypass when full, even if a pop occurs in the same cycle. A simultaneous push and pop while not full keeps the occupancy unchanged. Pointers wrap modulo FIFO_DEPTH and use an extra MSB to distinguish full from empty.
- **FSM states:**
  - IDLE: if the FIFO is not empty, pop the head into the issue registers and go to ISSUE; otherwise stay.
  - ISSUE: assert exactly one of `cam_write` (write command) or `cam_search` (search command) for this single cycle. `cam_addr` carries `cmd_addr` for a write and 0 for a search. `cam_data` carries the data or key. Next state is IDLE for a write. For a search, load the wait counter with CAM_LATENCY and go to WAIT.
  - WAIT: decrement the counter each cycle. When it reaches 0, capture `cam_match_addr` and `cam_found` into `res_addr` and `res_found`, then go to RESP.
  - RESP: `res_valid` is 1. When `res_valid & res_ready`, go to IDLE. `res_addr` and `res_found` hold their values until the next capture.
- `cam_addr` and `cam_data` are registered and hold their last issued values between strobes.
- Commands execute strictly in order. A write queued behind a search is not issued until the search result has been consumed.
- Accepting commands is independent of the FSM state. The FIFO keeps filling during WAIT and RESP.
- **Reset mid-operation:** flushes the FIFO and drops any pending strobe or result. `res_valid` falls on the reset edge.

## Timing
- A command pushed at edge N is popped at edge N+1 (FSM in IDLE). Its strobe is high during cycle N+1→N+2.
- Write throughput: one command every 2 cycles.
- Search: the strobe is issued in cycle S. `cam_*` inputs are sampled at edge S+CAM_LATENCY+1. `res_valid` rises in the cycle after that edge.
- With `res_ready` held at 1, a search occupies CAM_LATENCY+3 cycles from pop to return to IDLE.

## Configuration
- `CAM_SEQ_STATS_EN`, when defined:
  - Adds outputs `stat_writes` and `stat_searches`, 8 bits each, plus `stat_hits`, also 8 bits.
  - `stat_writes` / `stat_searches` increment on each write / search strobe.
  - `stat_hits` increments on each capture with `cam_found = 1`.
  - All three saturate at 255 and reset to 0.
- When undefined: these ports and counters do not exist, and behaviour is otherwise identical.

## Test plan
- **Reset:** assert `rst` for 2 cycles mid-search. Expect `res_valid = 0`, `cmd_ready = 1`, strobes at 0, and no issue afterward from the flushed commands.
- **Write:** push write addr=5, data=0xA3. Expect `cam_write = 1` for exactly one cycle, one cycle after acceptance, with `cam_addr = 5` and `cam_data = 0xA3`. No `res_valid`.
- **Search hit:** CAM_LATENCY=1; the CAM model returns addr 5, found 1 for key 0xA3. Push search 0xA3. Expect `res_valid` 3 cycles after the strobe cycle's start, with `res_addr = 5` and `res_found = 1`.
- **Backpressure:** hold `res_ready = 0` after a search, then push 4 writes. Expect `cmd_ready = 0` after the 4th write and no `cam_write` strobes. Release `res_ready`: the 4 writes issue at a 2-cycle cadence, in order.
- **Search miss then write ordering:** push search 0x11 (`cam_found = 0`), then write addr=31, data=0x11. Expect result `res_found = 0`, and `cam_write` only after the result handshake.
- **Stats (with `CAM_SEQ_STATS_EN`):** perform 3 writes and 2 searches, one of which hits. Expect stat_writes=3, stat_searches=2, stat_hits=1. Then 300 writes: expect `stat_writes` to saturate at 255.
